// File: rtl/mem_copy_strided_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_copy_strided_pkg : shared constants for the strided copy engine |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_copy_strided_pkg;

   // Deepest source-memory read latency the drain counter has to cover
   localparam int RD_LATENCY_MAX = 4;
   localparam int DRAIN_W        = `CLOG2(RD_LATENCY_MAX);

endpackage

`default_nettype wire

// File: rtl/mem_copy_strided_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_copy_strided_if : control, source-read and dest-write bundle    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mem_copy_strided_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 4
);
   logic              i_start;
   logic              i_abort;
   logic [AW-1:0]     i_src_base;
   logic [AW-1:0]     i_dst_base;
   logic [AW-1:0]     i_src_stride;
   logic [AW-1:0]     i_dst_stride;
   logic [AW:0]       i_count;
   logic [AW-1:0]     o_mem_in_addr;
   logic              o_mem_in_en;
   logic [WIDTH-1:0]  i_mem_in;
   logic [AW-1:0]     o_mem_out_addr;
   logic              o_mem_out_en;
   logic [WIDTH-1:0]  o_mem_out;
   logic              o_busy;
   logic              o_done;

   // Copy engine side
   modport slave (
      input  i_start, i_abort, i_src_base, i_dst_base, i_src_stride,
             i_dst_stride, i_count, i_mem_in,
      output o_mem_in_addr, o_mem_in_en, o_mem_out_addr, o_mem_out_en,
             o_mem_out, o_busy, o_done
   );

   // Host / memory side
   modport master (
      output i_start, i_abort, i_src_base, i_dst_base, i_src_stride,
             i_dst_stride, i_count, i_mem_in,
      input  o_mem_in_addr, o_mem_in_en, o_mem_out_addr, o_mem_out_en,
             o_mem_out, o_busy, o_done
   );
endinterface

`default_nettype wire

// File: rtl/mem_copy_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_copy_pipe : fixed-depth valid/data delay line, sync flush       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_copy_pipe #(
   parameter int DEPTH  = 1,
   parameter int DATA_W = 4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              flush,
   input  wire logic              in_valid,
   input  wire logic [DATA_W-1:0] in_data,
   output logic                   out_valid,
   output logic [DATA_W-1:0]      out_data
);

   logic [DEPTH-1:0]             valid;
   logic [DEPTH-1:0]             valid_in;
   logic [DEPTH-1:0][DATA_W-1:0] data;
   logic [DEPTH-1:0][DATA_W-1:0] data_in;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign valid_in[i] = in_valid;
         assign data_in[i]  = in_data;
      end else begin : g_tail
         assign valid_in[i] = valid[i-1];
         assign data_in[i]  = data[i-1];
      end
   end

   // Flush only kills the valids; stale data behind them is harmless
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         data  <= '0;
      end else begin
         valid <= flush ? '0 : valid_in;
         data  <= data_in;
      end
   end

   assign out_valid = valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/mem_copy_strided.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_copy_strided : strided word copy between two memories           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_copy_strided
   import mem_copy_strided_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int MAX_MEM_DEPTH = 16,
   parameter int RD_LATENCY    = 1
) (
   input  wire logic          i_clk,
   input  wire logic          i_rst,
   mem_copy_strided_if.slave  bus
);

   localparam int AW = `CLOG2(MAX_MEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state;
   logic [AW-1:0]      src_stride;
   logic [AW-1:0]      dst_stride;
   logic [AW-1:0]      src_next;
   logic [AW-1:0]      dst_next;
   logic [AW-1:0]      rd_addr;
   logic [AW-1:0]      rd_dst;
   logic [AW:0]        remaining;
   logic [DRAIN_W-1:0] drain_cnt;
   logic               rd_en;
   logic               busy;
   logic               done;
   logic               flush;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [WIDTH-1:0]   rd_data;

   // Abort acts on the same edge in both the FSM and the delay line
   assign flush = bus.i_abort && ((state == S_READ) || (state == S_DRAIN));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         src_stride <= '0;
         dst_stride <= '0;
         src_next   <= '0;
         dst_next   <= '0;
         rd_addr    <= '0;
         rd_dst     <= '0;
         remaining  <= '0;
         drain_cnt  <= '0;
         rd_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.i_start) begin
                  busy       <= 1'b1;
                  src_stride <= bus.i_src_stride;
                  dst_stride <= bus.i_dst_stride;
                  if (bus.i_count == '0) begin
                     state <= S_DONE;
                  end else begin
                     state     <= S_READ;
                     rd_en     <= 1'b1;
                     rd_addr   <= bus.i_src_base;
                     rd_dst    <= bus.i_dst_base;
                     src_next  <= bus.i_src_base + bus.i_src_stride;
                     dst_next  <= bus.i_dst_base + bus.i_dst_stride;
                     remaining <= bus.i_count - 1'b1;
                  end
               end
            end
            S_READ: begin
               if (bus.i_abort) begin
                  state <= S_IDLE;
                  rd_en <= 1'b0;
                  busy  <= 1'b0;
               end else if (remaining == '0) begin
                  rd_en <= 1'b0;
                  // The last write leaves the delay line while in DONE
                  if (RD_LATENCY == 1) begin
                     state <= S_DONE;
                  end else begin
                     state     <= S_DRAIN;
                     drain_cnt <= DRAIN_W'(RD_LATENCY - 2);
                  end
               end else begin
                  rd_addr   <= src_next;
                  rd_dst    <= dst_next;
                  src_next  <= src_next + src_stride;
                  dst_next  <= dst_next + dst_stride;
                  remaining <= remaining - 1'b1;
               end
            end
            S_DRAIN: begin
               if (bus.i_abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (drain_cnt == '0) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               rd_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   mem_copy_pipe #(
      .DEPTH  (RD_LATENCY),
      .DATA_W (AW)
   ) u_pipe (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (flush),
      .in_valid  (rd_en),
      .in_data   (rd_dst),
      .out_valid (wr_en),
      .out_data  (wr_addr)
   );

   assign rd_data            = bus.i_mem_in;
   assign bus.o_mem_out      = rd_data;
   assign bus.o_mem_in_en    = rd_en;
   assign bus.o_mem_in_addr  = rd_addr;
   assign bus.o_mem_out_en   = wr_en;
   assign bus.o_mem_out_addr = wr_addr;
   assign bus.o_busy         = busy;
   assign bus.o_done         = done;

endmodule

`default_nettype wire

// File: doc/mem_copy_strided.md
MEM_COPY_STRIDED -- requirements
Module: mem_copy_strided

Interface
REQ-001 SHALL take parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL take parameter MAX_MEM_DEPTH, default 16, meaning words per memory; AW = CLOG2(MAX_MEM_DEPTH) is the address width.
REQ-003 SHALL take parameter RD_LATENCY, default 1, legal 1..4, meaning source-memory cycles from read enable to valid i_mem_in.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port i_start, input, 1, single-cycle start request, sampled only in IDLE.
REQ-007 SHALL have port i_abort, input, 1, stop the transfer and flush the pipeline.
REQ-008 SHALL have ports i_src_base and i_dst_base, input, AW each, first source and first destination address.
REQ-009 SHALL have ports i_src_stride and i_dst_stride, input, AW each, address increment per word.
REQ-010 SHALL have port i_count, input, AW+1, number of words to copy (0..MAX_MEM_DEPTH).
REQ-011 SHALL have ports o_mem_in_addr (output, AW), o_mem_in_en (output, 1) and i_mem_in (input, WIDTH), the source read port.
REQ-012 SHALL have ports o_mem_out_addr (output, AW), o_mem_out_en (output, 1) and o_mem_out (output, WIDTH), the destination write port.
REQ-013 SHALL have ports o_busy (output, 1, high from the cycle after the accepted start until done/abort) and o_done (output, 1, one-cycle completion pulse).

Function
REQ-014 SHALL register i_src_base, i_dst_base, both strides and i_count in the cycle i_start is accepted; later changes to these inputs have no effect.
REQ-015 SHALL implement the states IDLE -> READ -> DRAIN -> DONE -> IDLE; a nonzero i_count moves IDLE to READ; i_count=0 moves IDLE directly to DONE.
REQ-016 In READ SHALL assert o_mem_in_en for exactly N consecutive cycles (N = latched count), with addresses src_base + k*src_stride mod 2^AW, k=0..N-1.
REQ-017 SHALL move READ -> DRAIN after the Nth read; DRAIN lasts until the last in-flight write has issued, then moves to DONE.
REQ-018 SHALL delay each read's enable and its destination address (dst_base + k*dst_stride mod 2^AW) through exactly RD_LATENCY register stages to form o_mem_out_en/o_mem_out_addr.
REQ-019 SHALL drive o_mem_out combinationally equal to i_mem_in, with no registering.
REQ-020 With start accepted at cycle 0: reads at cycles 1..N, writes at cycles 1+L..N+L (L = RD_LATENCY), o_done high at cycle N+L+1 only.
REQ-021 For i_count=0 SHALL issue no reads or writes; o_done pulses at cycle 2 and o_busy is high at cycle 1 only.
REQ-022 SHALL ignore i_start outside IDLE; a start in the cycle after o_done SHALL be accepted.
REQ-023 On i_abort in READ or DRAIN, SHALL deassert o_mem_in_en and o_mem_out_en in the next cycle, clear all pipeline valids, enter IDLE with o_busy low, and not pulse o_done.
REQ-024 i_abort in IDLE or DONE SHALL be ignored; i_abort together with i_start in IDLE SHALL start the transfer.
REQ-025 SHALL let address arithmetic wrap modulo 2^AW silently; overlapping source/destination ranges are the caller's responsibility.

Reset
REQ-026 When i_rst is high at a clock edge, SHALL enter IDLE, clear all pipeline valids and drive o_mem_in_en=0, o_mem_out_en=0, o_busy=0, o_done=0, o_mem_in_addr=0, o_mem_out_addr=0 from the next cycle.
REQ-027 Reset mid-transfer SHALL cancel the transfer with no further writes and no o_done pulse.
REQ-028 Reset SHALL take priority over i_start and i_abort.

Structure
REQ-029 SHALL use the CLOG2 macro from the shared param.v header; the state encodings SHALL be local parameters of this module.
REQ-030 SHALL put the RD_LATENCY-deep valid/address delay line in one sub-module, mem_copy_pipe, parameterised by depth and width, with a synchronous flush input.

Verification
REQ-031 L=1, src=2, dst=8, strides 1/1, count=4 -> writes to 8..11 with src words 2..5 at cycles 2..5; o_done at cycle 6.
REQ-032 L=3, src=0, src_stride=4, dst=1, dst_stride=1, count=4 -> reads at 0,4,8,12; writes at 1..4 at cycles 4..7; o_done at cycle 8.
REQ-033 count=0 -> no enables; o_done pulses at cycle 2.
REQ-034 src=14, stride=1, count=4, depth 16 -> reads at 14,15,0,1 (wrap-around).
REQ-035 count=8, L=2, i_abort at cycle 4 -> no enables from cycle 5; o_done never pulses; a new start at cycle 6 completes normally.
REQ-036 Reset at cycle 3 of a count=8 transfer -> all outputs 0 from cycle 4; no o_done pulse; a second i_start during busy is ignored.
